// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - pipelined immediate extender with valid/ready and a 2-entry skid buffer
module imm_extend_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int SHIFT = 2,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_ovf,
   output logic [TAG_W-1:0] out_tag
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_t;

   occ_t state;

   logic [OUT_W-1:0]       ext_data;
   logic                   ext_ovf;
   logic [OUT_W+SHIFT-1:0] shifted;
   logic [SHIFT:0]         top;

   logic [OUT_W-1:0] main_data;
   logic             main_ovf;
   logic [TAG_W-1:0] main_tag;
   logic [OUT_W-1:0] skid_data;
   logic             skid_ovf;
   logic [TAG_W-1:0] skid_tag;

   logic accept;
   logic drain;

   assign accept   = in_valid & in_ready;
   assign drain    = out_valid & out_ready;
   assign out_data = main_data;
   assign out_ovf  = main_ovf;
   assign out_tag  = main_tag;

   // Extension of the incoming immediate; the shift-overflow test checks that
   // every bit shifted past the result's sign bit still equals that sign bit
   always_comb begin
      shifted  = {{(OUT_W+SHIFT-IN_W){in_imm[IN_W-1]}}, in_imm} << SHIFT;
      top      = shifted[OUT_W+SHIFT-1:OUT_W-1];
      ext_data = '0;
      ext_ovf  = 1'b0;
      case (in_mode)
         2'b00: ext_data = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
         2'b01: ext_data = {{(OUT_W-IN_W){1'b0}}, in_imm};
         2'b10: begin
            ext_data = shifted[OUT_W-1:0];
            ext_ovf  = !((&top) || !(|top));
         end
         default: ext_data = {in_imm, {(OUT_W-IN_W){1'b0}}};
      endcase
   end

   // Occupancy FSM: main register feeds the output, skid catches one beat
   // while the consumer stalls; in_ready is registered so out_ready never
   // reaches it combinationally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         main_data <= '0;
         main_ovf  <= 1'b0;
         main_tag  <= '0;
         skid_data <= '0;
         skid_ovf  <= 1'b0;
         skid_tag  <= '0;
      end else begin
         in_ready <= 1'b1;
         case (state)
            EMPTY: begin
               if (accept) begin
                  main_data <= ext_data;
                  main_ovf  <= ext_ovf;
                  main_tag  <= in_tag;
                  out_valid <= 1'b1;
                  state     <= ONE;
               end
            end
            ONE: begin
               if (accept && drain) begin
                  main_data <= ext_data;
                  main_ovf  <= ext_ovf;
                  main_tag  <= in_tag;
               end else if (accept) begin
                  skid_data <= ext_data;
                  skid_ovf  <= ext_ovf;
                  skid_tag  <= in_tag;
                  in_ready  <= 1'b0;
                  state     <= TWO;
               end else if (drain) begin
                  out_valid <= 1'b0;
                  state     <= EMPTY;
               end
            end
            TWO: begin
               if (drain) begin
                  main_data <= skid_data;
                  main_ovf  <= skid_ovf;
                  main_tag  <= skid_tag;
                  state     <= ONE;
               end else begin
                  in_ready <= 1'b0;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= EMPTY;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - randomized scoreboard bench for imm_extend_pipe
module tb_imm_extend_pipe;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        in_valid, in_ready, out_valid, out_ready, out_ovf;
   logic [15:0] in_imm;
   logic [1:0]  in_mode;
   logic [4:0]  in_tag, out_tag;
   logic [31:0] out_data;

   logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_ovf_b;
   logic [15:0] in_imm_b;
   logic [1:0]  in_mode_b;
   logic [4:0]  in_tag_b, out_tag_b;
   logic [16:0] out_data_b;

   typedef struct {
      longint     data;
      bit         ovf;
      logic [4:0] tag;
   } beat_t;

   beat_t      sb[$];
   logic [4:0] seen[$];
   int         n_vec = 0;
   int         n_bad = 0;
   int         drained = 0;

   always #5 clk = ~clk;

   imm_extend_pipe #(.IN_W(16), .OUT_W(32), .SHIFT(2), .TAG_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
      .in_mode(in_mode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_ovf(out_ovf), .out_tag(out_tag)
   );

   imm_extend_pipe #(.IN_W(16), .OUT_W(17), .SHIFT(2), .TAG_W(5)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_imm(in_imm_b),
      .in_mode(in_mode_b), .in_tag(in_tag_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
      .out_ovf(out_ovf_b), .out_tag(out_tag_b)
   );

   task automatic chk(input string tag, input longint got, input longint exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: treat the immediate as an integer, scale it, then wrap to ow bits
   function automatic void ref_ext(input logic [15:0] imm, input logic [1:0] mode,
                                   input int ow, output longint data, output bit ovf);
      longint sv;
      longint m;
      longint v;
      sv  = imm[15] ? longint'(imm) - 65536 : longint'(imm);
      m   = longint'(1) << ow;
      ovf = 1'b0;
      case (mode)
         2'd0: v = sv;
         2'd1: v = longint'(imm);
         2'd2: begin
            v   = sv * 4;
            ovf = (v < -(m / 2)) || (v >= m / 2);
         end
         default: v = longint'(imm) * (longint'(1) << (ow - 16));
      endcase
      data = v & (m - 1);
   endfunction

   // One clock: observe both transfer kinds at the falling edge, then step
   task automatic tick();
      beat_t b;
      beat_t e;
      @(negedge clk);
      if (in_valid && in_ready) begin
         ref_ext(in_imm, in_mode, 32, b.data, b.ovf);
         b.tag = in_tag;
         sb.push_back(b);
      end
      if (out_valid && out_ready) begin
         drained++;
         seen.push_back(out_tag);
         chk("sb_nonempty", longint'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_data", longint'(out_data), e.data);
            chk("sb_ovf", longint'(out_ovf), longint'(e.ovf));
            chk("sb_tag", longint'(out_tag), longint'(e.tag));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic dir(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag,
                      input longint exp_data, input bit exp_ovf);
      in_imm   = imm;
      in_mode  = mode;
      in_tag   = tag;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("dir_valid", longint'(out_valid), 1);
      chk("dir_data", longint'(out_data), exp_data);
      chk("dir_ovf", longint'(out_ovf), longint'(exp_ovf));
      tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      longint d;
      bit     o;
      int     d0;
      rst_n = 1'b0;
      in_valid = 1'b0; in_imm = '0; in_mode = '0; in_tag = '0; out_ready = 1'b0;
      in_valid_b = 1'b0; in_imm_b = '0; in_mode_b = '0; in_tag_b = '0; out_ready_b = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", longint'(in_ready), 0);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_data", longint'(out_data), 0);
      chk("rst_out_ovf", longint'(out_ovf), 0);
      chk("rst_out_tag", longint'(out_tag), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rdy_before_edge", longint'(in_ready), 0);
      @(posedge clk);
      #1;
      chk("rdy_after_release", longint'(in_ready), 1);

      // Mode coverage
      out_ready = 1'b1;
      dir(16'h8001, 2'd0, 5'd1, 64'hFFFF8001, 1'b0);
      dir(16'h8001, 2'd1, 5'd2, 64'h00008001, 1'b0);
      dir(16'hFFFE, 2'd2, 5'd3, 64'hFFFFFFF8, 1'b0);
      dir(16'h1234, 2'd3, 5'd4, 64'h12340000, 1'b0);

      // Shift overflow on the 17-bit instance
      in_imm_b = 16'h4000; in_mode_b = 2'd2; in_tag_b = 5'd9; in_valid_b = 1'b1;
      @(posedge clk);
      #1;
      ref_ext(16'h4000, 2'd2, 17, d, o);
      chk("ovf_b_valid", longint'(out_valid_b), 1);
      chk("ovf_b_data", longint'(out_data_b), 64'h10000);
      chk("ovf_b_data_model", longint'(out_data_b), d);
      chk("ovf_b_flag", longint'(out_ovf_b), 1);
      in_imm_b = 16'h0001;
      @(posedge clk);
      #1;
      in_valid_b = 1'b0;
      chk("noovf_b_data", longint'(out_data_b), 64'h4);
      chk("noovf_b_flag", longint'(out_ovf_b), 0);
      chk("noovf_b_tag", longint'(out_tag_b), 9);

      // Backpressure: three beats against a stalled consumer
      out_ready = 1'b0;
      seen.delete();
      in_valid = 1'b1;
      for (int t = 1; t <= 2; t++) begin
         in_imm = 16'($urandom); in_mode = 2'($urandom); in_tag = 5'(t);
         tick();
      end
      in_imm = 16'($urandom); in_mode = 2'($urandom); in_tag = 5'd3;
      chk("bp_in_ready_full", longint'(in_ready), 0);
      chk("bp_head_tag", longint'(out_tag), 1);
      tick();
      tick();
      chk("bp_still_full", longint'(in_ready), 0);
      out_ready = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("bp_count", longint'(seen.size()), 3);
      if (seen.size() == 3) begin
         chk("bp_order0", longint'(seen[0]), 1);
         chk("bp_order1", longint'(seen[1]), 2);
         chk("bp_order2", longint'(seen[2]), 3);
      end

      // Stability under a held stall
      out_ready = 1'b0;
      in_imm = 16'h00FF; in_mode = 2'd0; in_tag = 5'd7; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk("hold_valid", longint'(out_valid), 1);
         chk("hold_data", longint'(out_data), 64'h000000FF);
         chk("hold_tag", longint'(out_tag), 7);
         tick();
      end
      out_ready = 1'b1;
      tick();

      // Reset with two beats held
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int t = 0; t < 2; t++) begin
         in_imm = 16'($urandom); in_mode = 2'($urandom); in_tag = 5'($urandom);
         tick();
      end
      in_valid = 1'b0;
      chk("mid_full_valid", longint'(out_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", longint'(out_valid), 0);
      chk("mid_rst_data", longint'(out_data), 0);
      chk("mid_rst_ready", longint'(in_ready), 0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rel_ready", longint'(in_ready), 1);
      chk("mid_rel_valid", longint'(out_valid), 0);
      out_ready = 1'b1;
      d0 = drained;
      repeat (3) tick();
      chk("mid_no_stale", longint'(drained - d0), 0);

      // Full-rate random stream
      chk("tp_sb_empty", longint'(sb.size()), 0);
      d0 = drained;
      in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         in_imm = 16'($urandom); in_mode = 2'($urandom); in_tag = 5'($urandom);
         if (i % 10 == 0) in_imm = (i % 20 == 0) ? 16'h8000 : 16'h7FFF;
         tick();
         chk("tp_in_ready", longint'(in_ready), 1);
      end
      in_valid = 1'b0;
      tick();
      chk("tp_out_count", longint'(drained - d0), 100);
      chk("tp_sb_drained", longint'(sb.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
